// File: rtl/pacman_ctrl_cmd_queue_if.sv
// pacman_ctrl_cmd_queue_if
// Turn-command stream between the keyboard command queue (master) and the
// Pac-Man movement FSM (slave). The master offers cmd_dir with cmd_valid and
// the slave takes the head by raising cmd_ready.

interface pacman_ctrl_cmd_queue_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dir;

    modport master (
        output cmd_valid,
        output cmd_dir,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        output cmd_ready
    );
endinterface

// File: rtl/pacman_ctrl_cmd_queue.sv
// pacman_ctrl_cmd_queue
// Turns the 32-bit keyboard control word from the SoC PIO (four HID keycode
// slots) into a FIFO of 2-bit turn commands (00 up, 01 down, 10 left,
// 11 right) and a one-cycle pause pulse on a new Esc press.
// Optional feature: define CTRL_DEDUP_EN to drop a push whose direction
// equals the entry currently at the tail of a non-empty FIFO.

module pacman_ctrl_cmd_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 0
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    input  logic [31:0]                control_in,
    pacman_ctrl_cmd_queue_if.master    cmd,
    output logic                       pause_pulse,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
    localparam logic             EXPIRY_EN  = (TIMEOUT > 0);
    // The head is discarded on the edge at which its age would reach TIMEOUT,
    // so it stays visible for exactly TIMEOUT cycles.
    localparam logic [23:0]      AGE_LAST   = (TIMEOUT > 0) ? 24'(TIMEOUT - 1) : 24'd0;

    localparam logic [7:0] KEY_UP_ARROW    = 8'h52;
    localparam logic [7:0] KEY_W           = 8'h1A;
    localparam logic [7:0] KEY_DOWN_ARROW  = 8'h51;
    localparam logic [7:0] KEY_S           = 8'h16;
    localparam logic [7:0] KEY_LEFT_ARROW  = 8'h50;
    localparam logic [7:0] KEY_A           = 8'h04;
    localparam logic [7:0] KEY_RIGHT_ARROW = 8'h4F;
    localparam logic [7:0] KEY_D           = 8'h07;
    localparam logic [7:0] KEY_ESC         = 8'h29;

    // {is_direction, direction} for one keycode
    function automatic logic [2:0] decode_dir(input logic [7:0] code);
        case (code)
            KEY_UP_ARROW,    KEY_W: return 3'b1_00;
            KEY_DOWN_ARROW,  KEY_S: return 3'b1_01;
            KEY_LEFT_ARROW,  KEY_A: return 3'b1_10;
            KEY_RIGHT_ARROW, KEY_D: return 3'b1_11;
            default:                return 3'b0_00;
        endcase
    endfunction

    // True when any of the four slots of word holds code
    function automatic logic held_in(input logic [7:0] code, input logic [31:0] word);
        logic hit;
        hit = 1'b0;
        for (int s = 0; s < 4; s++) begin
            if (word[8*s +: 8] == code) hit = 1'b1;
        end
        return hit;
    endfunction

    logic [31:0]      cur_q;
    logic [31:0]      prev_q;

    logic [1:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [23:0]      age;
    logic [1:0]       last_dir;

    logic [3:0]       slot_dir_new;
    logic [3:0]       slot_esc_new;
    logic [1:0]       slot_dir [4];

    logic             push_req;
    logic [1:0]       push_dir;
    logic             esc_new;
    logic             dup;
    logic             valid;
    logic             full;
    logic             pop;
    logic             expire;
    logic             remove;
    logic             do_push;
    logic             drop;
    logic [1:0]       head_dir;

    // Two-stage capture of the PIO word so presses are judged against the previous sample
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cur_q  <= 32'd0;
            prev_q <= 32'd0;
        end else begin
            cur_q  <= control_in;
            prev_q <= cur_q;
        end
    end

    // Per-slot new-press detection; a key that merely moved slots was already in prev_q
    always_comb begin
        slot_dir_new = 4'b0000;
        slot_esc_new = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            logic [2:0] dec;
            logic       fresh;
            dec         = decode_dir(cur_q[8*i +: 8]);
            fresh       = !held_in(cur_q[8*i +: 8], prev_q);
            slot_dir[i] = dec[1:0];
            if (fresh && dec[2])                       slot_dir_new[i] = 1'b1;
            if (fresh && cur_q[8*i +: 8] == KEY_ESC)   slot_esc_new[i] = 1'b1;
        end
    end

    // Lowest-index slot with a new direction wins; the rest are discarded
    always_comb begin
        push_dir = slot_dir[0];
        for (int i = 3; i >= 0; i--) begin
            if (slot_dir_new[i]) push_dir = slot_dir[i];
        end
    end

    assign push_req = |slot_dir_new;
    assign esc_new  = |slot_esc_new;

    assign valid    = (level != '0);
    assign full     = (level == FULL_LEVEL);
    assign head_dir = mem[rd_ptr];

`ifdef CTRL_DEDUP_EN
    logic [PTR_W-1:0] tail_ptr;
    assign tail_ptr = wr_ptr - PTR_W'(1);
    assign dup      = valid && (push_dir == mem[tail_ptr]);
`else
    assign dup      = 1'b0;
`endif

    assign pop     = valid && cmd.cmd_ready;
    assign expire  = EXPIRY_EN && valid && (age == AGE_LAST);
    assign remove  = pop || expire;
    assign do_push = push_req && !dup && (!full || remove);
    assign drop    = push_req && !dup && full && !remove;

    assign cmd.cmd_valid = valid;
    assign cmd.cmd_dir   = valid ? head_dir : last_dir;

    // FIFO storage; cleared on reset so the head never shows stale X data
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 2'b00;
        end else if (do_push) begin
            mem[wr_ptr] <= push_dir;
        end
    end

    // Pointer and occupancy bookkeeping; push and removal in one cycle cancel in level
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (remove)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, remove})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Head age: restarts whenever a different entry becomes head, counts while it waits
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            age <= 24'd0;
        end else if (!EXPIRY_EN) begin
            age <= 24'd0;
        end else if (remove || (do_push && !valid)) begin
            age <= 24'd0;
        end else if (valid) begin
            age <= age + 24'd1;
        end
    end

    // Remember the presented direction so it holds once the FIFO drains
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            last_dir <= 2'b00;
        end else begin
            last_dir <= cmd.cmd_dir;
        end
    end

    // Registered single-cycle status pulses
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pause_pulse <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            pause_pulse <= esc_new;
            overflow    <= drop;
        end
    end

endmodule

// File: tb/tb_pacman_ctrl_cmd_queue.sv
// tb_pacman_ctrl_cmd_queue
// Directed bench for pacman_ctrl_cmd_queue: one instance with expiry off
// (DEPTH 4) for queueing/overflow/pause/reset, one with TIMEOUT 10 for
// head expiry. Expected directions are kept in a scoreboard queue.
// Expectations for the duplicate-suppression step follow CTRL_DEDUP_EN.

module tb_pacman_ctrl_cmd_queue;

    logic        clk;
    logic        rst_n;
    logic [31:0] control;
    logic [31:0] control_to;
    logic        pause_pulse;
    logic        overflow;
    logic [2:0]  level;
    logic        pause_to;
    logic        overflow_to;
    logic [2:0]  level_to;

    int checks = 0;
    int errors = 0;
    logic [1:0] sb [$];

    pacman_ctrl_cmd_queue_if cmd_bus ();
    pacman_ctrl_cmd_queue_if to_bus ();

    pacman_ctrl_cmd_queue #(.DEPTH(4), .TIMEOUT(0)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .control_in    (control),
        .cmd           (cmd_bus),
        .pause_pulse   (pause_pulse),
        .overflow      (overflow),
        .level         (level)
    );

    pacman_ctrl_cmd_queue #(.DEPTH(4), .TIMEOUT(10)) dut_to (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .control_in    (control_to),
        .cmd           (to_bus),
        .pause_pulse   (pause_to),
        .overflow      (overflow_to),
        .level         (level_to)
    );

    // 10 ns system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Press a word for two edges (new-press latency), sample the pulses, then release
    task automatic apply_stimulus(input logic [31:0] word, output logic ov, output logic pp);
        control = word;
        tick(2);
        ov = overflow;
        pp = pause_pulse;
        control = 32'd0;
        tick(1);
    endtask

    // Take one entry from the head and compare it with the scoreboard
    task automatic pop_one(input string tag);
        logic [1:0] exp_dir;
        exp_dir = sb.pop_front();
        cmd_bus.cmd_ready = 1'b1;
        check_output({tag, " valid"}, 32'(cmd_bus.cmd_valid), 32'd1);
        check_output({tag, " dir"},   32'(cmd_bus.cmd_dir),   32'(exp_dir));
        tick(1);
        cmd_bus.cmd_ready = 1'b0;
    endtask

    initial begin
        logic ov;
        logic pp;
        logic [31:0] seq [5];

        rst_n = 1'b0;
        control = 32'd0;
        control_to = 32'd0;
        cmd_bus.cmd_ready = 1'b0;
        to_bus.cmd_ready = 1'b0;
        tick(2);

        check_output("reset valid",    32'(cmd_bus.cmd_valid), 32'd0);
        check_output("reset dir",      32'(cmd_bus.cmd_dir),   32'd0);
        check_output("reset level",    32'(level),             32'd0);
        check_output("reset pause",    32'(pause_pulse),       32'd0);
        check_output("reset overflow", 32'(overflow),          32'd0);
        rst_n = 1'b1;

        // Up arrow held: exactly one push
        control = 32'h0000_0052;
        tick(2);
        sb.push_back(2'b00);
        check_output("up valid", 32'(cmd_bus.cmd_valid), 32'd1);
        check_output("up dir",   32'(cmd_bus.cmd_dir),   32'd0);
        check_output("up level", 32'(level),             32'd1);
        tick(3);
        check_output("up hold level", 32'(level), 32'd1);

        // Same key moves to slot1: not a new press
        control = 32'h0000_5200;
        tick(3);
        check_output("slot move level", 32'(level), 32'd1);
        control = 32'd0;
        tick(1);
        pop_one("up pop");
        check_output("up empty valid", 32'(cmd_bus.cmd_valid), 32'd0);
        check_output("up empty level", 32'(level),             32'd0);

        // Left in slot0 and Down in slot1 together: only Left
        control = 32'h0000_5150;
        tick(2);
        sb.push_back(2'b10);
        check_output("multi level", 32'(level), 32'd1);
        tick(2);
        check_output("multi hold level", 32'(level), 32'd1);
        control = 32'd0;
        tick(1);
        pop_one("multi pop");

        // Fill to DEPTH, fifth press overflows
        seq[0] = 32'h52; seq[1] = 32'h51; seq[2] = 32'h50; seq[3] = 32'h4F; seq[4] = 32'h52;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(seq[i], ov, pp);
            sb.push_back(2'(i));
            check_output($sformatf("fill%0d overflow", i), 32'(ov),    32'd0);
            check_output($sformatf("fill%0d level", i),    32'(level), 32'(i + 1));
        end
        apply_stimulus(seq[4], ov, pp);
        check_output("overflow pulse", 32'(ov),       32'd1);
        check_output("overflow gone",  32'(overflow), 32'd0);
        check_output("full level",     32'(level),    32'd4);

        // Full FIFO: new press (W) coincides with a pop
        control = 32'h0000_001A;
        tick(1);
        cmd_bus.cmd_ready = 1'b1;
        check_output("swap head dir", 32'(cmd_bus.cmd_dir), 32'(sb[0]));
        tick(1);
        cmd_bus.cmd_ready = 1'b0;
        void'(sb.pop_front());
        sb.push_back(2'b00);
        check_output("swap level",    32'(level),    32'd4);
        check_output("swap overflow", 32'(overflow), 32'd0);
        control = 32'd0;
        tick(1);
        while (sb.size() > 0) pop_one("drain");
        check_output("drained valid",   32'(cmd_bus.cmd_valid), 32'd0);
        check_output("drained level",   32'(level),             32'd0);
        check_output("drained dir held", 32'(cmd_bus.cmd_dir),  32'd0);

        // Esc: pause pulse only
        apply_stimulus(32'h0000_0029, ov, pp);
        check_output("esc pulse",     32'(pp),          32'd1);
        check_output("esc pulse end", 32'(pause_pulse), 32'd0);
        check_output("esc level",     32'(level),       32'd0);

        // W then Up: duplicate when dedup is compiled in
        apply_stimulus(32'h0000_001A, ov, pp);
        sb.push_back(2'b00);
        apply_stimulus(32'h0000_0052, ov, pp);
`ifdef CTRL_DEDUP_EN
        check_output("dedup level", 32'(level), 32'd1);
`else
        sb.push_back(2'b00);
        check_output("dedup level", 32'(level), 32'd2);
`endif
        check_output("dedup overflow", 32'(ov), 32'd0);
        while (sb.size() > 0) pop_one("dedup drain");

        // Asynchronous reset mid-cycle with a key held through it
        apply_stimulus(32'h0000_0052, ov, pp);
        check_output("pre-reset level", 32'(level), 32'd1);
        control = 32'h0000_0016;
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check_output("async reset level", 32'(level),             32'd0);
        check_output("async reset valid", 32'(cmd_bus.cmd_valid), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check_output("release edge1 valid", 32'(cmd_bus.cmd_valid), 32'd0);
        tick(1);
        sb.push_back(2'b01);
        check_output("release edge2 valid", 32'(cmd_bus.cmd_valid), 32'd1);
        control = 32'd0;
        tick(1);
        pop_one("release pop");

        // Expiry: head discarded TIMEOUT cycles after becoming head
        control_to = 32'h0000_004F;
        tick(2);
        check_output("to valid",     32'(to_bus.cmd_valid), 32'd1);
        check_output("to level",     32'(level_to),         32'd1);
        tick(9);
        check_output("to still valid", 32'(to_bus.cmd_valid), 32'd1);
        tick(1);
        check_output("to expired valid", 32'(to_bus.cmd_valid), 32'd0);
        check_output("to expired level", 32'(level_to),         32'd0);
        check_output("to dir held",      32'(to_bus.cmd_dir),   32'd3);
        control_to = 32'd0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
